// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pulls one word per frame from a FIFO and sends it as UART.
// Define UART_TX_PARITY_EN to add the optional parity bit after the data.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_rd_inc,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_par;
  assign unused_par = i_par_en ^ i_par_typ;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  // State, bit timing and frame data registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // Next-state logic; every bit period clears the counter when it ends
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!i_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        // frame contents are frozen here; later input changes are ignored
        shreg_d   = i_rd_data;
`ifdef UART_TX_PARITY_EN
        par_en_d  = i_par_en;
        par_bit_d = (^i_rd_data) ^ i_par_typ;
`endif
        cnt_d     = '0;
        idx_d     = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state and frame registers only
  always_comb begin
    o_rd_inc = (state_q == S_LOAD);
    o_busy   = (state_q != S_IDLE);
    o_tx     = 1'b1;
    unique case (state_q)
      S_START:  o_tx = 1'b0;
      S_DATA:   o_tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: o_tx = par_bit_q;
`endif
      default:  o_tx = 1'b1;
    endcase
  end

endmodule
